// File: rtl/seq_mul_unit_if.sv
// Request/response bundle for the sequential multiplier: the requester drives
// the operation, the unit returns the selected product half with status.
interface seq_mul_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic [XLEN-1:0] result;
    logic            valid;
    logic            busy;

    modport master (
        output start, op, rs1, rs2, kill,
        input  result, valid, busy
    );

    modport slave (
        input  start, op, rs1, rs2, kill,
        output result, valid, busy
    );
endinterface

// File: rtl/seq_mul_unit.sv
// Radix-2^BPC shift-and-add multiplier on operand magnitudes; the sign is
// applied once at completion and the MUL/MULH* half is selected into result.
module seq_mul_unit #(
    parameter int XLEN = 32,
    parameter int BPC  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mul_unit_if.slave bus
);
    localparam int ITER  = XLEN / BPC;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_step;
    logic              w_last;

    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [2*XLEN-1:0] r_prod;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg;
    logic              r_op_hi;
    logic [XLEN-1:0]   r_result;

    op_t               w_op;
    logic              w_rs1_neg;
    logic              w_rs2_neg;
    logic [XLEN-1:0]   w_rs1_mag;
    logic [XLEN-1:0]   w_rs2_mag;
    logic [2*XLEN-1:0] w_sum;
    logic [2*XLEN-1:0] w_prod_fin;
    logic [XLEN-1:0]   w_sel;

    // Signedness is decided from the live op on the accepting edge only.
    assign w_op      = op_t'(bus.op);
    assign w_rs1_neg = (w_op != OP_MULHU) && bus.rs1[XLEN-1];
    assign w_rs2_neg = ((w_op == OP_MUL) || (w_op == OP_MULH)) && bus.rs2[XLEN-1];
    assign w_rs1_mag = w_rs1_neg ? -bus.rs1 : bus.rs1;
    assign w_rs2_mag = w_rs2_neg ? -bus.rs2 : bus.rs2;
    assign w_last    = (r_cnt == CNT_W'(ITER - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                // kill wins over everything, including a concurrent start
                if (bus.kill) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: blocking assignments are correct here: this is combinational
    // accumulation within one cycle, each partial sum feeding the next.
    always_comb begin
        w_sum = r_prod;
        for (int j = 0; j < BPC; j++) begin
            if (r_mplier[j]) w_sum = w_sum + (r_mcand << j);
        end
    end

    assign w_prod_fin = r_neg ? -w_sum : w_sum;
    assign w_sel      = r_op_hi ? w_prod_fin[2*XLEN-1:XLEN] : w_prod_fin[XLEN-1:0];

    // NOTE: datapath registers are reset as well, so nothing from an
    // aborted operation survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_op_hi  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{XLEN{1'b0}}, w_rs1_mag};
            r_mplier <= w_rs2_mag;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_neg    <= w_rs1_neg ^ w_rs2_neg;
            r_op_hi  <= (w_op != OP_MUL);
        end else if (w_step) begin
            r_prod   <= w_sum;
            r_mcand  <= r_mcand << BPC;
            r_mplier <= r_mplier >> BPC;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) r_result <= w_sel;
        end
    end

    assign bus.result = r_result;
    assign bus.valid  = (r_state == DONE);
    assign bus.busy   = (r_state == CALC);
endmodule
